// File: rtl/pdata_ctrl.sv
// pdata_ctrl: sequences a bit-serial MAC datapath through operand load, multiply, accumulator readout and clear.
module pdata_ctrl #(
  parameter int SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [SIZE-1:0]   a_in,
  input  logic [SIZE-1:0]   b_in,
  output logic              busy,
  output logic              done,
  output logic [4*SIZE-1:0] result,
  output logic [2:0]        opcode,
  output logic              rx,
  input  logic              tx
);
  localparam int CW = $clog2(4*SIZE);
  typedef enum logic [2:0] {
    OP_OUT_DATA1 = 3'd0, OP_OUT_DATA2 = 3'd1, OP_OUT_RES = 3'd2, OP_LOAD = 3'd3,
    OP_LOAD_RES = 3'd4, OP_MUL = 3'd5, OP_MUL_ADD = 3'd6, OP_NO_OP = 3'd7
  } opcode_t;
  typedef enum logic [2:0] {IDLE, LOAD, EXEC, READ, CLEAR, DONE} state_t;
  state_t              state;
  logic [CW-1:0]       cnt;
  logic [1:0]          op_q;
  logic [SIZE-1:0]     a_q, b_q;
  logic [4*SIZE-1:0]   rd_sr;
  logic                rx_q;
  logic [2*SIZE-1:0]   lsh;
  // next serial load bit: b then a, MSB-first
  assign lsh  = {b_q, a_q} << (cnt + CW'(1));
  assign busy = state != IDLE;
  assign done = state == DONE;
  // readout recirculates the accumulator, so rx mirrors tx within the cycle
  assign rx   = state == READ ? tx : rx_q;
  // EXEC also serves as the one-cycle dispatch slot for READ and CLR commands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      opcode <= OP_NO_OP;
      rx_q   <= 1'b0;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rd_sr  <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q   <= op;
          a_q    <= a_in;
          b_q    <= b_in;
          cnt    <= '0;
          state  <= op[1] ? EXEC : LOAD;
          opcode <= op[1] ? OP_NO_OP : OP_LOAD;
          rx_q   <= ~op[1] & b_in[SIZE-1];
        end
        LOAD: begin
          cnt  <= cnt + CW'(1);
          rx_q <= lsh[2*SIZE-1];
          if (cnt == CW'(2*SIZE-1)) begin
            state  <= EXEC;
            cnt    <= '0;
            rx_q   <= 1'b0;
            opcode <= op_q[0] ? OP_MUL_ADD : OP_MUL;
          end
        end
        EXEC: begin
          state  <= op_q == 2'd3 ? CLEAR : READ;
          opcode <= op_q == 2'd3 ? OP_LOAD_RES : OP_OUT_RES;
        end
        READ, CLEAR: begin
          cnt   <= cnt + CW'(1);
          rd_sr <= {rd_sr[4*SIZE-2:0], tx};
          if (cnt == CW'(4*SIZE-1)) begin
            state  <= DONE;
            cnt    <= '0;
            opcode <= OP_NO_OP;
            result <= state == READ ? {rd_sr[4*SIZE-2:0], tx} : '0;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pdata_ctrl.sv
// tb_pdata_ctrl: serial MAC datapath model plus command-timeline checker for pdata_ctrl.
module tb_pdata_ctrl;
  localparam int S = 4;
  localparam int W = 4*S;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0] op_i = '0;
  logic [S-1:0] a_i = '0, b_i = '0;
  logic busy, done, rx, tx;
  logic [W-1:0] result;
  logic [2:0] opcode;
  int n_chk = 0, n_bad = 0, ph = 0;
  logic [1:0] cop = '0;
  logic [S-1:0] ca = '0, cb = '0;
  logic [W-1:0] m_acc = '0, m_old = '0, m_new = '0;
  logic [S-1:0] d1, d2;
  logic [W-1:0] dacc;

  always #5 clk = ~clk;

  pdata_ctrl #(.SIZE(S)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op_i), .a_in(a_i), .b_in(b_i),
    .busy(busy), .done(done), .result(result), .opcode(opcode), .rx(rx), .tx(tx)
  );

  // serial datapath: two operand registers, accumulator, MSB-first shifting
  assign tx = opcode == 3'd2 ? dacc[W-1] : 1'b0;
  always @(posedge clk) begin
    case (opcode)
      3'd3: {d2, d1} <= {d2[S-2:0], d1, rx};
      3'd2, 3'd4: dacc <= {dacc[W-2:0], rx};
      3'd5: dacc <= W'(d1) * W'(d2);
      3'd6: dacc <= dacc + W'(d1) * W'(d2);
      default: ;
    endcase
  end

  function automatic int last(input logic [1:0] o);
    return o[1] ? W + 2 : 6*S + 2;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // command timeline: ph = cycles since the accepting edge, 0 when idle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0;
      m_old = '0;
      m_new = '0;
    end else if (ph == 0) begin
      if (start) begin
        ph = 1;
        cop = op_i;
        ca = a_i;
        cb = b_i;
        if (op_i == 2'd0) m_acc = W'(a_i) * W'(b_i);
        else if (op_i == 2'd1) m_acc = m_acc + W'(a_i) * W'(b_i);
        else if (op_i == 2'd3) m_acc = '0;
        m_new = m_acc;
      end
    end else if (ph == last(cop)) begin
      ph = 0;
      m_old = m_new;
    end else ph++;
  end

  always @(negedge clk) begin
    logic [2:0] eo;
    logic erx;
    logic [2*S-1:0] sq;
    eo = 3'd7;
    erx = 1'b0;
    sq = {cb, ca};
    if (!rst && ph > 0 && ph < last(cop)) begin
      if (!cop[1]) eo = ph <= 2*S ? 3'd3 : ph == 2*S + 1 ? (cop[0] ? 3'd6 : 3'd5) : 3'd2;
      else eo = ph == 1 ? 3'd7 : cop[0] ? 3'd4 : 3'd2;
    end
    if (eo == 3'd3) erx = 1'(sq >> (2*S - ph));
    else if (eo == 3'd2) erx = tx;
    chk("opcode", W'(opcode), W'(eo));
    chk("busy", W'(busy), W'(!rst && ph > 0));
    chk("done", W'(done), W'(!rst && ph == last(cop)));
    chk("rx", W'(rx), W'(erx));
    chk("result", result, rst ? '0 : ph == last(cop) ? m_new : m_old);
  end

  task automatic launch(input logic [1:0] o, input logic [S-1:0] a, input logic [S-1:0] b);
    @(posedge clk);
    #1 start = 1'b1; op_i = o; a_i = a; b_i = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run(input logic [1:0] o, input logic [S-1:0] a, input logic [S-1:0] b,
                     input logic [W-1:0] er, input int el, input bit g);
    int c;
    launch(o, a, b);
    c = 1;
    while (!done && c < 200) begin
      if (g && c == 3) begin
        start = 1'b1;
        a_i = ~a;
        op_i = 2'd3;
      end else start = 1'b0;
      @(posedge clk);
      #1 c++;
    end
    chk("latency", W'(c), W'(el));
    chk("cmd_result", result, er);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_opcode", W'(opcode), W'(7));
    chk("rst_busy", W'(busy), '0);
    chk("rst_result", result, '0);
    rst = 1'b0;
    run(2'd3, 0, 0, 0, 18, 1'b0);
    run(2'd2, 0, 0, 0, 18, 1'b0);
    run(2'd0, 3, 5, 15, 26, 1'b0);
    run(2'd1, 2, 7, 29, 26, 1'b0);
    run(2'd2, 0, 0, 29, 18, 1'b0);
    run(2'd3, 0, 0, 0, 18, 1'b0);
    run(2'd1, 15, 15, 225, 26, 1'b0);
    run(2'd1, 15, 15, 450, 26, 1'b0);
    run(2'd1, 15, 15, 675, 26, 1'b0);
    run(2'd0, 3, 5, 15, 26, 1'b1);
    launch(2'd2, 0, 0);
    repeat (12) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_opcode", W'(opcode), W'(7));
    chk("midrst_busy", W'(busy), '0);
    chk("midrst_result", result, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    run(2'd3, 0, 0, 0, 18, 1'b0);
    run(2'd0, 1, 1, 1, 26, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/pdata_ctrl.md
PDATA_CTRL -- requirements
Module: pdata_ctrl

Interface
REQ-001 SHALL have parameter: SIZE, 32, operand width in bits; accumulator/result width is 4*SIZE.
REQ-002 SHALL have parameter: OPCODE encodings, fixed: OUT_DATA1=0, OUT_DATA2=1, OUT_RES=2, LOAD=3, LOAD_RES=4, MUL=5, MUL_ADD=6, NO_OP=7.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request strobe; sampled only in IDLE.
REQ-006 op  input  2  command: 0=MUL (acc=a*b), 1=MAC (acc+=a*b), 2=READ (read acc only), 3=CLR (acc=0).
REQ-007 a_in  input  SIZE  operand A, captured when start is accepted.
REQ-008 b_in  input  SIZE  operand B, captured when start is accepted.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse; result valid in that cycle.
REQ-011 result  output  4*SIZE  last accumulator value read out; held until the next read completes.
REQ-012 opcode  output  3  registered opcode to the serial MAC datapath.
REQ-013 rx  output  1  registered serial bit to the datapath.
REQ-014 tx  input  1  serial bit from the datapath, combinational from opcode.

Function
REQ-015 SHALL implement states IDLE, LOAD, EXEC, READ, CLEAR, DONE with one bit counter wide enough for 4*SIZE.
REQ-016 In IDLE, opcode SHALL be NO_OP and rx 0.
REQ-017 start high in IDLE SHALL latch op, a_in and b_in, then go to LOAD (op 0/1), READ (op 2) or CLEAR (op 3).
REQ-018 start SHALL be ignored in all states other than IDLE, and the latched operands SHALL not change.
REQ-019 LOAD SHALL last exactly 2*SIZE cycles with opcode=LOAD.
REQ-020 During LOAD, rx SHALL drive b MSB-first for SIZE cycles, then a MSB-first for SIZE cycles, so the datapath ends with data_2=b and data_1=a.
REQ-021 EXEC SHALL last 1 cycle with opcode=MUL for op 0 or MUL_ADD for op 1, then go to READ.
REQ-022 READ SHALL last exactly 4*SIZE cycles with opcode=OUT_RES.
REQ-023 During READ, each cycle SHALL shift tx into result LSB (MSB-first readout), and rx SHALL equal tx in the same cycle.
REQ-024 This recirculation SHALL leave the datapath accumulator unchanged after READ completes.
REQ-025 result SHALL be updated only from a completed READ; no partial value is visible, so result uses a separate shift register copied on READ completion.
REQ-026 CLEAR SHALL last 4*SIZE cycles with opcode=LOAD_RES and rx=0, then go to DONE, and result SHALL be set to 0.
REQ-027 DONE SHALL last 1 cycle: done=1, opcode=NO_OP, then IDLE; start is accepted at the earliest on the IDLE cycle that follows.
REQ-028 Latency from the start-sampling edge: op 0/1 done in cycle 6*SIZE+2; op 2/3 done in cycle 4*SIZE+2.
REQ-029 MAC arithmetic wrap-around modulo 2^(4*SIZE) is the datapath's behaviour; the controller SHALL apply no saturation.
REQ-030 Counter terminal compare SHALL use the exact cycle counts above, with no off-by-one at 4*SIZE-1.

Reset
REQ-031 rst high SHALL immediately force IDLE, opcode=NO_OP, rx=0, busy=0, done=0, result=0, counter=0 and latched operands=0, in any state.
REQ-032 Datapath contents after a mid-operation reset are undefined to the controller; the system clears them by issuing CLR.

Verification (SIZE=4)
REQ-033 Reset; op=3 (CLR); then op=2 (READ) -> result=0, done in cycle 18 of the READ command.
REQ-034 op=0, a=3, b=5 -> opcode LOAD for 8 cycles, then MUL for 1, then OUT_RES for 16; result=15, done in cycle 26.
REQ-035 Then op=1, a=2, b=7 -> result=29; then op=2 -> result=29 (accumulator preserved by recirculation).
REQ-036 op=1, a=15, b=15, issued 3 times from acc=0 -> results 225, 450, 675.
REQ-037 start pulsed while busy (mid-LOAD, with different a_in) -> ignored; the original command completes with the original result.
REQ-038 rst asserted mid-READ -> same cycle: opcode=NO_OP, busy=0, result=0; after CLR then MUL a=1, b=1 -> result=1.
